// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: runs loads and stores against a fixed-latency
// SRAM, freezes the upstream pipeline while an access is in flight, and owns the
// register-file write-back register.
module mem_wb_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned SRAM_ADDR_W = 17,
  parameter int unsigned MEM_BASE    = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      st_val,
  input  logic [REG_ADDR_W-1:0]  dest_in,
  output logic                   freeze,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_dq_out,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  input  logic [DATA_W-1:0]      sram_dq_in,
  output logic                   wb_en,
  output logic [REG_ADDR_W-1:0]  wb_dest,
  output logic [DATA_W-1:0]      wb_result
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   rd_q, rd_d;       // latched operation: 1 = load, 0 = store
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      dq_q, dq_d;       // doubles as the latched store value
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0]  wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0]      wb_result_q, wb_result_d;
  logic                   req;

  assign req         = mem_r_en_in | mem_w_en_in;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign wb_en       = wb_en_q;
  assign wb_dest     = wb_dest_q;
  assign wb_result   = wb_result_q;

  // Stall upstream from the cycle a request appears until the access completes.
  always_comb begin
    freeze = rst & (((state_q == StIdle) & req) | (state_q == StAccess));
  end

  // Next-state logic for the access FSM, SRAM strobes and write-back register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    dq_d        = dq_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    wb_en_d     = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_result_d = wb_result_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Read wins when both enables are set; no write is issued then.
          rd_d    = mem_r_en_in;
          addr_d  = SRAM_ADDR_W'((alu_result - DATA_W'(MEM_BASE)) >> 2);
          dq_d    = st_val;
          we_n_d  = mem_r_en_in;
          oe_n_d  = ~mem_r_en_in;
          cnt_d   = CntW'(1);
          state_d = StAccess;
        end else begin
          wb_en_d     = wb_en_in;
          wb_dest_d   = dest_in;
          wb_result_d = alu_result;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WAIT_CYCLES)) begin
          if (rd_q) rdata_d = sram_dq_in;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // The held instruction is still on the inputs; stores never write back.
        if (rd_q) begin
          wb_en_d     = wb_en_in;
          wb_dest_d   = dest_in;
          wb_result_d = rdata_q;
        end
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any access in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      dq_q        <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      wb_en_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_result_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      wb_en_q     <= wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_result_q <= wb_result_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random instructions, checked against a
// cycle-schedule reference model and an SRAM model with a word-keyed memory.
module tb_mem_wb_stage;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned REG_ADDR_W  = 4;
  localparam int unsigned SRAM_ADDR_W = 17;
  localparam int unsigned MEM_BASE    = 1024;
  localparam int unsigned WAIT_CYCLES = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [DATA_W-1:0]      alu_result, st_val, sram_dq_in;
  logic [REG_ADDR_W-1:0]  dest_in;
  logic                   freeze, sram_we_n, sram_oe_n, wb_en;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0]      sram_dq_out, wb_result;
  logic [REG_ADDR_W-1:0]  wb_dest;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .SRAM_ADDR_W(SRAM_ADDR_W),
    .MEM_BASE(MEM_BASE), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_result(alu_result), .st_val(st_val),
    .dest_in(dest_in), .freeze(freeze), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_dq_in(sram_dq_in), .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result)
  );

  int checks = 0;
  int errors = 0;

  // Expected values for the current cycle.
  logic                   exp_freeze, exp_we_n, exp_oe_n, exp_wb_en;
  logic [REG_ADDR_W-1:0]  exp_wb_dest;
  logic [DATA_W-1:0]      exp_wb_result, exp_dq;
  logic [SRAM_ADDR_W-1:0] exp_addr;
  logic                   chk_win, chk_dq;

  // SRAM contents as seen by the DUT, and as the reference model believes them.
  logic [DATA_W-1:0] dut_mem [logic [SRAM_ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [SRAM_ADDR_W-1:0]];
  int unsigned oe_run = 0;

  function automatic logic [DATA_W-1:0] init_word(input logic [SRAM_ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = DATA_W'(a);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: SRAM model drives read data, outputs are compared, edge taken.
  task automatic step();
    logic we_s, oe_s;
    logic [SRAM_ADDR_W-1:0] a_s;
    logic [DATA_W-1:0] d_s;
    // Valid data only in the last strobe cycle; garbage otherwise.
    if (!sram_oe_n && (oe_run + 1 == WAIT_CYCLES))
      sram_dq_in = dut_mem.exists(sram_addr) ? dut_mem[sram_addr] : init_word(sram_addr);
    else
      sram_dq_in = $urandom;
    #1;
    chk("freeze", {31'b0, freeze}, {31'b0, exp_freeze});
    chk("sram_we_n", {31'b0, sram_we_n}, {31'b0, exp_we_n});
    chk("sram_oe_n", {31'b0, sram_oe_n}, {31'b0, exp_oe_n});
    chk("wb_en", {31'b0, wb_en}, {31'b0, exp_wb_en});
    chk("wb_dest", {28'b0, wb_dest}, {28'b0, exp_wb_dest});
    chk("wb_result", wb_result, exp_wb_result);
    if (chk_win) chk("sram_addr", {15'b0, sram_addr}, {15'b0, exp_addr});
    if (chk_win && chk_dq) chk("sram_dq_out", sram_dq_out, exp_dq);
    we_s = sram_we_n;
    oe_s = sram_oe_n;
    a_s  = sram_addr;
    d_s  = sram_dq_out;
    @(posedge clk);
    if (!we_s) dut_mem[a_s] = d_s;
    oe_run = oe_s ? 0 : oe_run + 1;
    @(negedge clk);
  endtask

  task automatic set_reset_expect();
    exp_freeze    = 1'b0;
    exp_we_n      = 1'b1;
    exp_oe_n      = 1'b1;
    exp_wb_en     = 1'b0;
    exp_wb_dest   = '0;
    exp_wb_result = '0;
    chk_win       = 1'b0;
    chk_dq        = 1'b0;
  endtask

  // Present one instruction and run it to completion (or reset it at phase abort_p).
  task automatic run_instr(input logic we, input logic rd, input logic wr,
                           input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] st,
                           input logic [REG_ADDR_W-1:0] dst, input int abort_p);
    logic [DATA_W-1:0] word;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [DATA_W-1:0] ld;
    wb_en_in    = we;
    mem_r_en_in = rd;
    mem_w_en_in = wr;
    alu_result  = alu;
    st_val      = st;
    dest_in     = dst;
    if (!(rd || wr)) begin
      exp_freeze = 1'b0;
      exp_we_n   = 1'b1;
      exp_oe_n   = 1'b1;
      chk_win    = 1'b0;
      step();
      exp_wb_en     = we;
      exp_wb_dest   = dst;
      exp_wb_result = alu;
      return;
    end
    word = (alu - DATA_W'(MEM_BASE)) / 4;
    addr = word[SRAM_ADDR_W-1:0];
    for (int p = 0; p <= int'(WAIT_CYCLES) + 1; p++) begin
      if (p == abort_p) begin
        #3;
        rst = 1'b0;
        #1;
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        chk("rst_freeze", {31'b0, freeze}, 32'd0);
        chk("rst_addr", {15'b0, sram_addr}, 32'd0);
        chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        oe_run = 0;
        set_reset_expect();
        return;
      end
      exp_freeze = (p <= int'(WAIT_CYCLES));
      chk_win    = (p >= 1) && (p <= int'(WAIT_CYCLES));
      chk_dq     = !rd;
      exp_we_n   = !(!rd && chk_win);
      exp_oe_n   = !(rd && chk_win);
      exp_addr   = addr;
      exp_dq     = st;
      step();
      exp_wb_en = 1'b0;
    end
    chk_win = 1'b0;
    if (rd) begin
      ld            = ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr);
      exp_wb_en     = we;
      exp_wb_dest   = dst;
      exp_wb_result = ld;
    end else begin
      ref_mem[addr] = st;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] a;
    int unsigned kind;
    rst         = 1'b1;
    wb_en_in    = 1'b1;
    mem_r_en_in = 1'b1;
    mem_w_en_in = 1'b0;
    alu_result  = $urandom;
    st_val      = $urandom;
    dest_in     = 4'($urandom);
    sram_dq_in  = $urandom;
    set_reset_expect();
    #2;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset holds everything idle even with a load request on the inputs.
    chk("reset_freeze", {31'b0, freeze}, 32'd0);
    chk("reset_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("reset_oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("reset_wb_en", {31'b0, wb_en}, 32'd0);
    chk("reset_wb_dest", {28'b0, wb_dest}, 32'd0);
    chk("reset_wb_result", wb_result, 32'd0);
    chk("reset_sram_addr", {15'b0, sram_addr}, 32'd0);
    chk("reset_sram_dq_out", sram_dq_out, 32'd0);
    rst = 1'b1;

    // Directed steps.
    run_instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, -1);
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, -1);
    run_instr(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd7, -1);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, -1);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd1, -1);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd2, -1);
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, -1);
    run_instr(1'b1, 1'b0, 1'b1, 32'd1424, 32'hCAFEF00D, 4'd9, 3);
    run_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd4, -1);
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, -1);

    // Random instruction mix, including both enables and misaligned/wrapping addresses.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 7);
      a    = 32'(MEM_BASE) + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      if (kind == 7) a = $urandom;
      case (kind)
        0, 1, 2: run_instr(1'($urandom), 1'b0, 1'b0, $urandom, $urandom,
                           4'($urandom), -1);
        3, 4:    run_instr(1'($urandom), 1'b1, 1'b0, a, $urandom, 4'($urandom), -1);
        5:       run_instr(1'($urandom), 1'b1, 1'b1, a, $urandom, 4'($urandom), -1);
        default: run_instr(1'($urandom), 1'b0, 1'b1, a, $urandom, 4'($urandom), -1);
      endcase
    end
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
